pdp8_phase_sequencer: RTL and testbench
=======================================

# pdp8_phase_sequencer

Parametrised major-state/phase sequencer for the PDP-8 CPU core. It replaces the fixed six-phase sequencer with a configurable number of execute phases and a configurable phase length. It adds single-step, halt-at-boundary and overrun detection. Its CK/STB phase strobes drive every instruction-handling block (fetch/indirect, 0–5xxx, OPR, IOT) and it is gated by their OR'ed DONE.

## Interface
Parameters:
- N_EXEC, 6, number of execute phases (2..15).
- PHASE_LEN, 2, cycles per phase (2..8).
- EN_AUTO, 1, 1 = autoindex phases AUTO1/AUTO2 exist; 0 = SEQTYPE 1x is treated as 01.

Ports:
- SYSCLK  in  1  system clock; everything on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RUN  in  1  level; start/continue execution.
- HALT  in  1  level; request stop at the next instruction boundary.
- STEP  in  1  one-cycle pulse; execute exactly one instruction from IDLE.
- DONE  in  1  instruction complete; sampled only in execute STB cycles.
- SEQTYPE  in  2  {PPIND,IND}; sampled in the FETCH STB cycle.
- CK_FETCH, CK_AUTO1, CK_AUTO2, CK_IND  out  1 each  phase-active levels.
- STB_FETCH, STB_AUTO1, STB_AUTO2, STB_IND  out  1 each  last-cycle strobes.
- CK_EXEC  out  N_EXEC  execute phase-active levels; bit 0 = phase 1.
- STB_EXEC  out  N_EXEC  execute strobes.
- RUNNING  out  1  high in every non-IDLE state.
- OVERRUN  out  1  one-cycle pulse: last execute phase ended without DONE.

## Operation
- States: IDLE, FETCH, AUTO1, AUTO2, IND, EXEC(k) for k = 1..N_EXEC. A phase counter 0..PHASE_LEN-1 runs inside each non-IDLE state.
- The CK output of the current state is high for all PHASE_LEN cycles of the phase. Its STB output is high only when counter = PHASE_LEN-1. At most one CK and one STB are high at any time.
- IDLE→FETCH occurs when (RUN & ~HALT) | STEP. STEP sets the internal step_mode flag.
- At the end of FETCH, the next state depends on SEQTYPE:
  - 00 → EXEC(1)
  - 01 → IND
  - 1x → AUTO1 if EN_AUTO, otherwise IND
- AUTO1→AUTO2→IND→EXEC(1), each taking one full phase.
- At the end of EXEC(k):
  - If DONE=1 or k=N_EXEC, the instruction ends.
  - Otherwise the next state is EXEC(k+1).
  - If k=N_EXEC and DONE=0, OVERRUN pulses in the same STB cycle.
- At instruction end, the next state is IDLE if halt_req | step_mode | ~RUN; otherwise FETCH. Entering IDLE clears halt_req and step_mode.
- halt_req is set by HALT=1 in any non-IDLE cycle and persists until IDLE.
- STEP while not IDLE is ignored. STEP together with HALT in IDLE still executes one instruction.
- DONE outside execute STB cycles has no effect. DONE in the same cycle as an instruction end takes the normal end path.

## Timing
- On RESET (synchronous):
  - State goes to IDLE and the phase counter to 0.
  - halt_req and step_mode are cleared.
  - All CK, STB, RUNNING and OVERRUN outputs are 0 from the cycle after the reset edge.
  - Reset mid-phase aborts immediately; no STB is emitted.
- Outputs are registered: a start condition seen at edge n gives CK_FETCH=1 from cycle n+1.
- Instruction length is PHASE_LEN × (1 + indirect phases + execute phases used).
- With the defaults, a direct instruction that finishes at EXEC(2) occupies 6 cycles. The next CK_FETCH follows the last STB with no gap.
- The counter wraps from PHASE_LEN-1 to 0 on every phase change.

## Structure
- The shared package pdp8_seq_pkg holds:
  - the state enum;
  - the SEQTYPE encodings SEQ_DIR=2'b00, SEQ_IND=2'b01, SEQ_PPIND=2'b1x;
  - localparam widths derived from N_EXEC/PHASE_LEN via $clog2.
- One sub-module, pdp8_phase_timer: a PHASE_LEN counter with a last-cycle flag and synchronous clear.

## Test plan
- Reset, then RUN=1 with SEQTYPE=00 and DONE at STB_EXEC[1] (defaults) → CK_FETCH high in cycles 1–2, CK_EXEC[0] in cycles 3–4, CK_EXEC[1] in cycles 5–6, CK_FETCH again at cycle 7.
- SEQTYPE=11 with EN_AUTO=1 → phase order FETCH, AUTO1, AUTO2, IND, EXEC1; SEQTYPE=11 with EN_AUTO=0 → FETCH, IND, EXEC1.
- DONE never asserted, N_EXEC=4 → OVERRUN=1 exactly in the STB_EXEC[3] cycle, followed by FETCH.
- HALT pulsed during EXEC(1), instruction ends at EXEC(3) → IDLE follows; RUNNING=0 and all CK=0 while RUN stays 1.
- STEP pulse in IDLE with RUN=0 → exactly one instruction, then IDLE; a STEP pulse mid-instruction has no effect.
- RESET asserted in cycle 2 of EXEC(2) with PHASE_LEN=4 → next cycle all outputs 0, state IDLE, no STB pulse.

Source files
------------

// File: rtl/pdp8_seq_pkg.sv
// pdp8_seq_pkg: shared sequencer state encoding, SEQTYPE codes and width helpers
package pdp8_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_AUTO1, S_AUTO2, S_IND, S_EXEC} seq_state_t;
  localparam logic [1:0] SEQ_DIR = 2'b00;
  localparam logic [1:0] SEQ_IND = 2'b01;
  localparam logic [1:0] SEQ_PPIND = 2'b10;
  localparam int EXEC_W = $clog2(15 + 1);
  function automatic int cnt_w(input int len);
    return len > 1 ? $clog2(len) : 1;
  endfunction
endpackage

// File: rtl/pdp8_phase_timer.sv
// pdp8_phase_timer: PHASE_LEN cycle counter (clk, rst, clr in; last out high on final cycle), wraps to 0 each phase
module pdp8_phase_timer
  import pdp8_seq_pkg::*;
#(
  parameter int PHASE_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic last
);
  localparam int W = cnt_w(PHASE_LEN);
  logic [W-1:0] cnt;
  assign last = cnt == W'(PHASE_LEN - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else cnt <= last ? '0 : cnt + W'(1);
endmodule

// File: rtl/pdp8_phase_sequencer.sv
// pdp8_phase_sequencer: PDP-8 major-state sequencer; RUN/HALT/STEP/DONE/SEQTYPE in, per-phase CK/STB levels, RUNNING and OVERRUN out
module pdp8_phase_sequencer
  import pdp8_seq_pkg::*;
#(
  parameter int N_EXEC = 6,
  parameter int PHASE_LEN = 2,
  parameter bit EN_AUTO = 1'b1
) (
  input  logic              SYSCLK,
  input  logic              RESET,
  input  logic              RUN,
  input  logic              HALT,
  input  logic              STEP,
  input  logic              DONE,
  input  logic [1:0]        SEQTYPE,
  output logic              CK_FETCH,
  output logic              CK_AUTO1,
  output logic              CK_AUTO2,
  output logic              CK_IND,
  output logic              STB_FETCH,
  output logic              STB_AUTO1,
  output logic              STB_AUTO2,
  output logic              STB_IND,
  output logic [N_EXEC-1:0] CK_EXEC,
  output logic [N_EXEC-1:0] STB_EXEC,
  output logic              RUNNING,
  output logic              OVERRUN
);
  seq_state_t state, state_n;
  logic [EXEC_W-1:0] k, k_n;
  logic halt_req, halt_req_n, step_mode, step_mode_n;
  logic last, idle, in_exec, k_last, inst_end, stop;
  pdp8_phase_timer #(.PHASE_LEN(PHASE_LEN)) u_timer (
    .clk (SYSCLK),
    .rst (RESET),
    .clr (idle),
    .last(last)
  );
  assign idle = state == S_IDLE;
  assign in_exec = state == S_EXEC;
  assign k_last = k == EXEC_W'(N_EXEC);
  assign inst_end = in_exec && last && (DONE || k_last);
  assign stop = halt_req || HALT || step_mode || !RUN;
  always_ff @(posedge SYSCLK)
    if (RESET) begin
      state <= S_IDLE;
      k <= '0;
      halt_req <= 1'b0;
      step_mode <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      halt_req <= halt_req_n;
      step_mode <= step_mode_n;
    end
  always_comb begin
    state_n = state;
    k_n = k;
    halt_req_n = halt_req || (HALT && !idle);
    step_mode_n = step_mode;
    if (idle && ((RUN && !HALT) || STEP)) begin
      state_n = S_FETCH;
      step_mode_n = STEP;
    end else if (last) begin
      case (state)
        S_FETCH: begin
          state_n = EN_AUTO && (SEQTYPE & SEQ_PPIND) != SEQ_DIR ? S_AUTO1 :
                    SEQTYPE == SEQ_DIR ? S_EXEC : S_IND;
          k_n = EXEC_W'(1);
        end
        S_AUTO1: state_n = S_AUTO2;
        S_AUTO2: state_n = S_IND;
        S_IND: begin
          state_n = S_EXEC;
          k_n = EXEC_W'(1);
        end
        S_EXEC: begin
          state_n = !inst_end ? S_EXEC : stop ? S_IDLE : S_FETCH;
          k_n = k + EXEC_W'(1);
        end
        default: state_n = state;
      endcase
    end
    if (state_n == S_IDLE) begin
      halt_req_n = 1'b0;
      step_mode_n = 1'b0;
    end
  end
  assign CK_FETCH = state == S_FETCH;
  assign CK_AUTO1 = state == S_AUTO1;
  assign CK_AUTO2 = state == S_AUTO2;
  assign CK_IND = state == S_IND;
  assign STB_FETCH = CK_FETCH && last;
  assign STB_AUTO1 = CK_AUTO1 && last;
  assign STB_AUTO2 = CK_AUTO2 && last;
  assign STB_IND = CK_IND && last;
  assign CK_EXEC = in_exec ? {{(N_EXEC - 1){1'b0}}, 1'b1} << (k - EXEC_W'(1)) : '0;
  assign STB_EXEC = last ? CK_EXEC : '0;
  assign RUNNING = !idle;
  assign OVERRUN = in_exec && last && k_last && !DONE;
endmodule

// File: tb/tb_pdp8_phase_sequencer.sv
// tb_pdp8_phase_sequencer: directed phase-table checks on a default and an (N_EXEC=4, PHASE_LEN=4, EN_AUTO=0) sequencer
module tb_pdp8_phase_sequencer;
  localparam logic [9:0] P_Z = 10'd0, P_F = 10'd1, P_A1 = 10'd2, P_A2 = 10'd4, P_I = 10'd8;
  localparam logic [9:0] P_E1 = 10'd16, P_E2 = 10'd32, P_E3 = 10'd64, P_E4 = 10'd128;
  logic SYSCLK = 1'b0;
  logic RESET = 1'b0, RUN = 1'b0, HALT = 1'b0, STEP = 1'b0, DONE = 1'b0;
  logic [1:0] SEQTYPE = 2'b00;
  wire [9:0] ck0, stb0;
  wire [7:0] ck1, stb1;
  wire run0, ov0, run1, ov1;
  logic [9:0] ph [8];
  int n_vec = 0, n_err = 0;
  always #5 SYSCLK = ~SYSCLK;
  pdp8_phase_sequencer d0 (
    .SYSCLK(SYSCLK), .RESET(RESET), .RUN(RUN), .HALT(HALT), .STEP(STEP), .DONE(DONE), .SEQTYPE(SEQTYPE),
    .CK_FETCH(ck0[0]), .CK_AUTO1(ck0[1]), .CK_AUTO2(ck0[2]), .CK_IND(ck0[3]),
    .STB_FETCH(stb0[0]), .STB_AUTO1(stb0[1]), .STB_AUTO2(stb0[2]), .STB_IND(stb0[3]),
    .CK_EXEC(ck0[9:4]), .STB_EXEC(stb0[9:4]), .RUNNING(run0), .OVERRUN(ov0)
  );
  pdp8_phase_sequencer #(.N_EXEC(4), .PHASE_LEN(4), .EN_AUTO(1'b0)) d1 (
    .SYSCLK(SYSCLK), .RESET(RESET), .RUN(RUN), .HALT(HALT), .STEP(STEP), .DONE(DONE), .SEQTYPE(SEQTYPE),
    .CK_FETCH(ck1[0]), .CK_AUTO1(ck1[1]), .CK_AUTO2(ck1[2]), .CK_IND(ck1[3]),
    .STB_FETCH(stb1[0]), .STB_AUTO1(stb1[1]), .STB_AUTO2(stb1[2]), .STB_IND(stb1[3]),
    .CK_EXEC(ck1[7:4]), .STB_EXEC(stb1[7:4]), .RUNNING(run1), .OVERRUN(ov1)
  );
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge SYSCLK);
    @(negedge SYSCLK);
  endtask
  task automatic check_out(input string tag, input int sel, input logic [9:0] ck, input logic [9:0] stb,
                           input logic run, input logic ov);
    check({tag, " ck"}, sel != 0 ? {2'b00, ck1} : ck0, ck);
    check({tag, " stb"}, sel != 0 ? {2'b00, stb1} : stb0, stb);
    check({tag, " running"}, {9'd0, sel != 0 ? run1 : run0}, {9'd0, run});
    check({tag, " overrun"}, {9'd0, sel != 0 ? ov1 : ov0}, {9'd0, ov});
  endtask
  task automatic do_reset;
    RESET = 1'b1; RUN = 1'b0; HALT = 1'b0; STEP = 1'b0; DONE = 1'b0; SEQTYPE = 2'b00;
    tick;
    RESET = 1'b0;
    #1;
    check_out("reset d0", 0, P_Z, P_Z, 1'b0, 1'b0);
    check_out("reset d1", 1, P_Z, P_Z, 1'b0, 1'b0);
  endtask
  task automatic run_phases(input string tag, input int sel, input int np, input int done_ph,
                            input int ov_ph, input int halt_ph, input int step_ph);
    int len;
    logic l;
    for (int p = 0; p < np; p++) begin
      len = ph[p] == P_Z ? 1 : (sel != 0 ? 4 : 2);
      for (int c = 0; c < len; c++) begin
        l = (c == len - 1) && ph[p] != P_Z;
        DONE = (p == done_ph) && l;
        HALT = (p == halt_ph) && c == 0;
        STEP = (p == step_ph) && c == 0;
        #1;
        check_out($sformatf("%s p%0d c%0d", tag, p, c), sel, ph[p], l ? ph[p] : P_Z,
                  ph[p] != P_Z, (p == ov_ph) && l);
        tick;
      end
    end
    DONE = 1'b0; HALT = 1'b0; STEP = 1'b0;
  endtask
  initial begin
    @(negedge SYSCLK);
    do_reset;
    RUN = 1'b1;
    #1;
    check_out("start latency", 0, P_Z, P_Z, 1'b0, 1'b0);
    tick;
    ph = '{P_F, P_E1, P_E2, P_F, P_Z, P_Z, P_Z, P_Z};
    run_phases("direct", 0, 4, 2, -1, -1, -1);
    do_reset;
    RUN = 1'b1; SEQTYPE = 2'b11;
    tick;
    ph = '{P_F, P_A1, P_A2, P_I, P_E1, P_F, P_Z, P_Z};
    run_phases("autoidx", 0, 6, 4, -1, -1, -1);
    do_reset;
    RUN = 1'b1; SEQTYPE = 2'b11;
    tick;
    ph = '{P_F, P_I, P_E1, P_F, P_Z, P_Z, P_Z, P_Z};
    run_phases("noauto", 1, 4, 2, -1, -1, -1);
    do_reset;
    RUN = 1'b1;
    tick;
    ph = '{P_F, P_E1, P_E2, P_E3, P_E4, P_F, P_Z, P_Z};
    run_phases("overrun", 1, 6, -1, 4, -1, -1);
    do_reset;
    RUN = 1'b1;
    tick;
    ph = '{P_F, P_E1, P_E2, P_E3, P_Z, P_F, P_Z, P_Z};
    run_phases("halt", 0, 6, 3, -1, 1, -1);
    do_reset;
    STEP = 1'b1;
    tick;
    ph = '{P_F, P_E1, P_Z, P_Z, P_Z, P_Z, P_Z, P_Z};
    run_phases("step", 0, 4, 1, -1, -1, -1);
    do_reset;
    RUN = 1'b1;
    tick;
    ph = '{P_F, P_E1, P_E2, P_F, P_Z, P_Z, P_Z, P_Z};
    run_phases("step ignored", 0, 4, 2, -1, -1, 1);
    do_reset;
    RUN = 1'b1;
    tick;
    ph = '{P_F, P_E1, P_Z, P_Z, P_Z, P_Z, P_Z, P_Z};
    run_phases("midreset", 1, 2, -1, -1, -1, -1);
    #1;
    check_out("midreset e2 c0", 1, P_E2, P_Z, 1'b1, 1'b0);
    tick;
    RESET = 1'b1; RUN = 1'b0;
    #1;
    check_out("midreset e2 c1", 1, P_E2, P_Z, 1'b1, 1'b0);
    tick;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_out($sformatf("midreset after %0d", i), 1, P_Z, P_Z, 1'b0, 1'b0);
      tick;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
